mem_fill_responder: RTL and testbench
=====================================

Name: mem_fill_responder

Overview:
Memory-side responder for the cache-fill protocol.
- The cache fill state machine issues single-word reads, single-word writes and block-fill burst reads; this block services them from a word-addressed storage array.
- Every read response returns a fixed LATENCY cycles after issue.
- Sits between the I/D cache fill logic and backing storage; replaces ad-hoc multi-cycle memory models in simulation and synthesis.

Parameters:
MEM_AW, 10, word-index width; storage holds 2**MEM_AW 16-bit words, indexed by req_addr[MEM_AW:1]
LATENCY, 4, issue-to-response delay in cycles (legal range 1..8)
BURST_WORDS, 8, words per block-fill burst (power of 2; 8 words = 16-byte cache block)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
req_vld  input  1  request valid
req_wr  input  1  1 = write, 0 = read
req_burst  input  1  read only: 1 = block-fill burst
req_addr  input  16  byte address; bit 0 ignored
req_wdata  input  16  write data
req_rdy  output  1  request accepted when req_vld && req_rdy at rising edge
rsp_vld  output  1  response data valid, one cycle per word
rsp_data  output  16  read data
rsp_addr  output  16  byte address of the word in rsp_data (bit 0 = 0)
rsp_last  output  1  final word of a response (always 1 for single reads)

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE; all pipeline valids cleared.
  - rsp_vld, rsp_data, rsp_addr, rsp_last = 0; req_rdy = 0 while rst is low.
  - Storage contents are not reset.
  - Reset mid-burst or with reads in flight discards them all; no response is emitted after release.
- Index: idx = req_addr[MEM_AW:1]. Upper address bits are ignored, so addresses alias/wrap.
- FSM states:
  - IDLE: req_rdy = 1.
  - BURST: req_rdy = 0.
  - req_rdy is decoded from state only; it does not depend on req_vld.
- Write accept (IDLE): mem[idx] <= req_wdata at the accept edge; no response generated; req_burst ignored.
- Single-read accept (IDLE, req_burst = 0):
  - mem[idx] is sampled at the accept edge T0 into pipeline stage 1.
  - rsp_vld = 1 for exactly the cycle following edge T0+LATENCY-1, i.e. visible at edge T0+LATENCY; rsp_last = 1; rsp_addr = {req_addr[15:1], 1'b0}.
  - Back-to-back single reads are accepted every cycle and responses return in order, one per cycle.
- Burst accept (IDLE, req_burst = 1, req_wr = 0):
  - IDLE -> BURST at T0.
  - base = req_addr with bits [log2(BURST_WORDS):0] cleared.
  - Internal issue of word i (address base + 2i) at edge T0+i, for i = 0..BURST_WORDS-1; word 0 is issued at T0.
  - BURST -> IDLE at edge T0+BURST_WORDS-1, so req_rdy is high again from that edge.
  - Responses: BURST_WORDS consecutive rsp_vld cycles starting at edge T0+LATENCY; rsp_last = 1 on the final word only.
- Read data is sampled at issue. A write accepted at edge T sees any read issued before T return old data and any read issued at or after T+1 return new data.
- A burst never reads a write issued during that burst (no writes accepted in BURST).
- Single reads in flight when a burst is accepted drain first; responses never overlap because issue is one per cycle and the pipeline is fixed-length.
- The pipeline is a LATENCY-deep shift register of {vld, addr, data, last}; the output registers are the final stage.
- rsp_data/rsp_addr/rsp_last hold their last values when rsp_vld = 0.

Optional Feature:
CRITICAL_WORD_FIRST_EN
- Defined: a burst starts at the requested word w = req_addr[log2(BURST_WORDS):1] and wraps within the block. Word i is issued for offset (w+i) mod BURST_WORDS; rsp_addr reflects the actual word returned; rsp_last is on the BURST_WORDS-th response.
- Undefined: a burst always starts at offset 0, ascending.

Test Plan:
- Reset then write 0xBEEF @0x0010, read @0x0010 (LATENCY=4) -> rsp_vld exactly 4 edges after read accept, rsp_data = 0xBEEF, rsp_addr = 0x0010, rsp_last = 1.
- Preload mem[i] = 0x1000+i; burst read @0x0026 -> req_rdy low for 7 cycles; 8 responses on consecutive cycles:
  - Macro off: rsp_addr 0x0020..0x002E, data 0x1010..0x1017.
  - Macro on: first rsp_addr = 0x0026, wrapping to 0x0024; rsp_last on the 8th response only.
- Reads of 0x0000, 0x0002, 0x0004 on consecutive cycles -> 3 consecutive responses in order, each rsp_last = 1, no bubbles.
- Read @0x0008 (old value 0x1111), then next cycle write 0x2222 @0x0008, then read @0x0008 -> responses 0x1111 then 0x2222.
- Assert rst low 2 cycles into a burst -> rsp_vld stays 0 after release, req_rdy = 1 one cycle after release, and a new single read completes normally.
- Address aliasing with MEM_AW = 10: write 0xA5A5 @0x0802, read @0x0002 -> rsp_data = 0xA5A5.

Source files
------------

// File: rtl/mem_fill_responder.sv
// mem_fill_responder: fixed-latency word memory serving single reads, writes and block-fill bursts.
// Define CRITICAL_WORD_FIRST_EN to start bursts at the requested word and wrap within the block.
module mem_fill_responder #(
    parameter int MEM_AW      = 10,
    parameter int LATENCY     = 4,
    parameter int BURST_WORDS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_vld,
    input  logic        req_wr,
    input  logic        req_burst,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        req_rdy,
    output logic        rsp_vld,
    output logic [15:0] rsp_data,
    output logic [15:0] rsp_addr,
    output logic        rsp_last
);
    localparam int OW = $clog2(BURST_WORDS);

    typedef enum logic {IDLE, BURST} state_t;

    state_t          state_q, state_d;
    logic [OW-1:0]   cnt_q, cnt_d, off_q, off_d, cur_off, start_off;
    logic [14-OW:0]  blk_q, blk_d;
    logic [15:0]     mem [2**MEM_AW];
    logic            acc, start, iss_vld, iss_last;
    logic [15:0]     iss_addr;
    logic            pv_q [LATENCY];
    logic            pv_d [LATENCY];
    logic            pl_q [LATENCY];
    logic            pl_d [LATENCY];
    logic [15:0]     pa_q [LATENCY];
    logic [15:0]     pa_d [LATENCY];
    logic [15:0]     pd_q [LATENCY];
    logic [15:0]     pd_d [LATENCY];
    logic            unused_addr_lsb;

    assign unused_addr_lsb = req_addr[0];

    always_comb begin
        req_rdy = rst && state_q == IDLE;
        acc     = req_vld && req_rdy;
        start   = acc && !req_wr && req_burst;
`ifdef CRITICAL_WORD_FIRST_EN
        start_off = req_addr[OW:1];
`else
        start_off = '0;
`endif
        cur_off = off_q + cnt_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        off_d   = off_q;
        blk_d   = blk_q;
        if (start) begin
            state_d = BURST;
            cnt_d   = OW'(1);
            off_d   = start_off;
            blk_d   = req_addr[15:OW+1];
        end else if (state_q == BURST) begin
            cnt_d   = cnt_q + OW'(1);
            state_d = &cnt_q ? IDLE : BURST;
        end
        // Word 0 of a burst issues on the accept edge, the rest from the counter
        iss_vld  = (acc && !req_wr) || state_q == BURST;
        iss_last = state_q == BURST ? &cnt_q : !req_burst;
        iss_addr = state_q == BURST ? {blk_q, cur_off, 1'b0} :
                   req_burst        ? {req_addr[15:OW+1], start_off, 1'b0} :
                                      {req_addr[15:1], 1'b0};
        pv_d = pv_q;
        pl_d = pl_q;
        pa_d = pa_q;
        pd_d = pd_q;
        pv_d[0] = iss_vld;
        pl_d[0] = iss_vld ? iss_last : pl_q[0];
        pa_d[0] = iss_vld ? iss_addr : pa_q[0];
        pd_d[0] = iss_vld ? mem[iss_addr[MEM_AW:1]] : pd_q[0];
        for (int k = 1; k < LATENCY; k++) begin
            pv_d[k] = pv_q[k-1];
            pl_d[k] = pv_q[k-1] ? pl_q[k-1] : pl_q[k];
            pa_d[k] = pv_q[k-1] ? pa_q[k-1] : pa_q[k];
            pd_d[k] = pv_q[k-1] ? pd_q[k-1] : pd_q[k];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            off_q   <= '0;
            blk_q   <= '0;
            pv_q    <= '{default: 1'b0};
            pl_q    <= '{default: 1'b0};
            pa_q    <= '{default: 16'h0};
            pd_q    <= '{default: 16'h0};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            off_q   <= off_d;
            blk_q   <= blk_d;
            pv_q    <= pv_d;
            pl_q    <= pl_d;
            pa_q    <= pa_d;
            pd_q    <= pd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (acc && req_wr) mem[req_addr[MEM_AW:1]] <= req_wdata;
    end

    assign rsp_vld  = pv_q[LATENCY-1];
    assign rsp_last = pl_q[LATENCY-1];
    assign rsp_addr = pa_q[LATENCY-1];
    assign rsp_data = pd_q[LATENCY-1];
endmodule

// File: tb/tb_mem_fill_responder.sv
// tb_mem_fill_responder: randomized and directed checks against a queue-based reference model.
module tb_mem_fill_responder;
    localparam int L  = 4;
    localparam int BW = 8;
    localparam int AW = 10;
`ifdef CRITICAL_WORD_FIRST_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif

    typedef struct packed {
        int unsigned cyc;
        logic [15:0] addr;
        logic [15:0] data;
        logic        last;
    } rsp_t;

    logic        clk = 1'b0, rst = 1'b1, req_vld = 1'b0, req_wr = 1'b0, req_burst = 1'b0;
    logic [15:0] req_addr = '0, req_wdata = '0;
    logic        req_rdy, rsp_vld, rsp_last;
    logic [15:0] rsp_data, rsp_addr;

    rsp_t        exp_q[$];
    rsp_t        obs_q[$];
    logic [15:0] mem_m [2**AW];
    int unsigned cyc = 0;
    int          total = 0, bad = 0;

    mem_fill_responder #(.MEM_AW(AW), .LATENCY(L), .BURST_WORDS(BW)) dut (
        .clk(clk), .rst(rst), .req_vld(req_vld), .req_wr(req_wr), .req_burst(req_burst),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_rdy(req_rdy), .rsp_vld(rsp_vld),
        .rsp_data(rsp_data), .rsp_addr(rsp_addr), .rsp_last(rsp_last)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (rsp_vld) obs_q.push_back('{cyc, rsp_addr, rsp_data, rsp_last});

    // Called at a negedge; the request is accepted on the following posedge once req_rdy is high.
    task automatic issue(input logic wr, input logic burst, input logic [15:0] addr, input logic [15:0] wdata);
        int unsigned t0;
        int          n, off;
        logic [15:0] base, a;
        req_vld = 1'b1; req_wr = wr; req_burst = burst; req_addr = addr; req_wdata = wdata;
        n = 0;
        while (!req_rdy && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_rdy) begin
            total++; bad++;
            $display("FAIL accept_timeout req_rdy=%0b want 1", req_rdy);
        end else begin
            t0 = cyc + 1;
            if (wr) mem_m[addr[AW:1]] = wdata;
            else if (!burst) exp_q.push_back('{t0 + L - 1, {addr[15:1], 1'b0}, mem_m[addr[AW:1]], 1'b1});
            else begin
                base = addr & ~16'(2 * BW - 1);
                for (int i = 0; i < BW; i++) begin
                    off = CWF ? (int'(addr >> 1) % BW + i) % BW : i;
                    a   = base + 16'(2 * off);
                    exp_q.push_back('{t0 + 32'(i) + L - 1, a, mem_m[a[AW:1]], i == BW - 1});
                end
            end
        end
        @(negedge clk);
        req_vld = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        total += 5;
        if (req_rdy !== 1'b0) begin bad++; $display("FAIL reset_rdy got=%b want=0", req_rdy); end
        if (rsp_vld !== 1'b0) begin bad++; $display("FAIL reset_vld got=%b want=0", rsp_vld); end
        if (rsp_data !== 16'h0) begin bad++; $display("FAIL reset_data got=%h want=0000", rsp_data); end
        if (rsp_addr !== 16'h0) begin bad++; $display("FAIL reset_addr got=%h want=0000", rsp_addr); end
        if (rsp_last !== 1'b0) begin bad++; $display("FAIL reset_last got=%b want=0", rsp_last); end
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (req_rdy !== 1'b1) begin bad++; $display("FAIL release_rdy got=%b want=1", req_rdy); end
        for (int i = 0; i < 2**AW; i++) issue(1'b1, 1'b0, 16'(2 * i), 16'(16'h1000 + i));
    endtask

    task automatic test_single();
        rsp_t o;
        issue(1'b1, 1'b0, 16'h0010, 16'hBEEF);
        issue(1'b0, 1'b0, 16'h0010, 16'h0);
        repeat (L + BW + 2) @(negedge clk);
        total++;
        if (obs_q.size() == 0 || obs_q[0].data !== 16'hBEEF) begin
            bad++; $display("FAIL single_data got=%h want=beef", obs_q.size() ? obs_q[0].data : 16'h0);
        end
        total++;
        if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL single_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            o = i < obs_q.size() ? obs_q[i] : rsp_t'(0);
            total++;
            if (o !== exp_q[i]) begin
                bad++;
                $display("FAIL single_rsp%0d got cyc=%0d a=%h d=%h l=%b want cyc=%0d a=%h d=%h l=%b",
                         i, o.cyc, o.addr, o.data, o.last, exp_q[i].cyc, exp_q[i].addr, exp_q[i].data, exp_q[i].last);
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_burst();
        rsp_t o;
        issue(1'b0, 1'b1, 16'h0026, 16'h0);
        for (int i = 0; i < BW - 1; i++) begin
            total++;
            if (req_rdy !== 1'b0) begin bad++; $display("FAIL burst_rdy_low%0d got=%b want=0", i, req_rdy); end
            @(negedge clk);
        end
        total++;
        if (req_rdy !== 1'b1) begin bad++; $display("FAIL burst_rdy_back got=%b want=1", req_rdy); end
        repeat (L + BW) @(negedge clk);
        total++;
        if (obs_q.size() == 0 || obs_q[0].addr !== (CWF ? 16'h0026 : 16'h0020)) begin
            bad++; $display("FAIL burst_first_addr got=%h want=%h", obs_q.size() ? obs_q[0].addr : 16'h0, CWF ? 16'h0026 : 16'h0020);
        end
        total++;
        if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL burst_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            o = i < obs_q.size() ? obs_q[i] : rsp_t'(0);
            total++;
            if (o !== exp_q[i]) begin
                bad++;
                $display("FAIL burst_rsp%0d got cyc=%0d a=%h d=%h l=%b want cyc=%0d a=%h d=%h l=%b",
                         i, o.cyc, o.addr, o.data, o.last, exp_q[i].cyc, exp_q[i].addr, exp_q[i].data, exp_q[i].last);
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_back_to_back();
        rsp_t o;
        issue(1'b0, 1'b0, 16'h0000, 16'h0);
        issue(1'b0, 1'b0, 16'h0002, 16'h0);
        issue(1'b0, 1'b0, 16'h0004, 16'h0);
        issue(1'b0, 1'b1, 16'h004A, 16'h0);
        repeat (L + BW + 2) @(negedge clk);
        total++;
        if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL b2b_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            o = i < obs_q.size() ? obs_q[i] : rsp_t'(0);
            total++;
            if (o !== exp_q[i]) begin
                bad++;
                $display("FAIL b2b_rsp%0d got cyc=%0d a=%h d=%h l=%b want cyc=%0d a=%h d=%h l=%b",
                         i, o.cyc, o.addr, o.data, o.last, exp_q[i].cyc, exp_q[i].addr, exp_q[i].data, exp_q[i].last);
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_read_after_write();
        rsp_t o;
        issue(1'b1, 1'b0, 16'h0008, 16'h1111);
        issue(1'b0, 1'b0, 16'h0008, 16'h0);
        issue(1'b1, 1'b0, 16'h0008, 16'h2222);
        issue(1'b0, 1'b0, 16'h0008, 16'h0);
        repeat (L + 2) @(negedge clk);
        total++;
        if (obs_q.size() < 2 || obs_q[0].data !== 16'h1111 || obs_q[1].data !== 16'h2222) begin
            bad++; $display("FAIL raw_order got=%0d rsps want 1111 then 2222", obs_q.size());
        end
        total++;
        if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL raw_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            o = i < obs_q.size() ? obs_q[i] : rsp_t'(0);
            total++;
            if (o !== exp_q[i]) begin
                bad++;
                $display("FAIL raw_rsp%0d got cyc=%0d a=%h d=%h l=%b want cyc=%0d a=%h d=%h l=%b",
                         i, o.cyc, o.addr, o.data, o.last, exp_q[i].cyc, exp_q[i].addr, exp_q[i].data, exp_q[i].last);
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset_mid_burst();
        rsp_t o;
        issue(1'b0, 1'b1, 16'h0060, 16'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        total += 2;
        if (rsp_vld !== 1'b0) begin bad++; $display("FAIL midrst_vld got=%b want=0", rsp_vld); end
        if (req_rdy !== 1'b0) begin bad++; $display("FAIL midrst_rdy got=%b want=0", req_rdy); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        total++;
        if (req_rdy !== 1'b1) begin bad++; $display("FAIL midrst_rdy_after got=%b want=1", req_rdy); end
        repeat (L + BW + 2) @(negedge clk);
        total++;
        if (obs_q.size() != 0) begin bad++; $display("FAIL midrst_stale got=%0d rsps want=0", obs_q.size()); end
        obs_q.delete();
        issue(1'b0, 1'b0, 16'h0062, 16'h0);
        repeat (L + 2) @(negedge clk);
        total++;
        if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL midrst_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            o = i < obs_q.size() ? obs_q[i] : rsp_t'(0);
            total++;
            if (o !== exp_q[i]) begin
                bad++;
                $display("FAIL midrst_rsp%0d got cyc=%0d a=%h d=%h l=%b want cyc=%0d a=%h d=%h l=%b",
                         i, o.cyc, o.addr, o.data, o.last, exp_q[i].cyc, exp_q[i].addr, exp_q[i].data, exp_q[i].last);
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_alias();
        issue(1'b1, 1'b0, 16'h0802, 16'hA5A5);
        issue(1'b0, 1'b0, 16'h0002, 16'h0);
        repeat (L + 2) @(negedge clk);
        total++;
        if (obs_q.size() != 1 || obs_q[0].data !== 16'hA5A5 || obs_q[0].addr !== 16'h0002) begin
            bad++;
            $display("FAIL alias got n=%0d d=%h a=%h want n=1 d=a5a5 a=0002", obs_q.size(),
                     obs_q.size() ? obs_q[0].data : 16'h0, obs_q.size() ? obs_q[0].addr : 16'h0);
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_random();
        rsp_t o;
        int   op;
        for (int n = 0; n < 120; n++) begin
            op = $urandom_range(0, 9);
            if (op < 3) issue(1'b1, 1'b0, 16'($urandom), 16'($urandom));
            else if (op < 8) issue(1'b0, 1'b0, 16'($urandom), 16'h0);
            else issue(1'b0, 1'b1, 16'($urandom), 16'h0);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
        repeat (L + BW + 2) @(negedge clk);
        total++;
        if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL random_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            o = i < obs_q.size() ? obs_q[i] : rsp_t'(0);
            total++;
            if (o !== exp_q[i]) begin
                bad++;
                $display("FAIL random_rsp%0d got cyc=%0d a=%h d=%h l=%b want cyc=%0d a=%h d=%h l=%b",
                         i, o.cyc, o.addr, o.data, o.last, exp_q[i].cyc, exp_q[i].addr, exp_q[i].data, exp_q[i].last);
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_back_to_back();
        test_read_after_write();
        test_reset_mid_burst();
        test_alias();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
